// File: rtl/tone_player.sv
// rtl/tone_player.sv - sequenced square-wave tone player with one-deep note buffer
module tone_player #(
  parameter int CLK_F    = 32,
  parameter int PERIOD_W = 32,
  parameter int DUR_W    = 16,
  parameter int GAP_MS   = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic [DUR_W-1:0]    note_dur,
  input  logic                note_valid,
  output logic                note_ready,
  output logic                tone_out,
  output logic                busy,
  output logic                done
);

  localparam int HALF = CLK_F / 2;
  localparam int PRE_W = $clog2(HALF + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(HALF - 1);
  localparam logic [DUR_W-1:0] GAP_LEN = DUR_W'(GAP_MS);
  localparam logic [10:0] MS_MAX = 11'd1999;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t              state;
  logic                hold_valid;
  logic [PERIOD_W-1:0] hold_period;
  logic [DUR_W-1:0]    hold_dur;
  logic [PERIOD_W-1:0] act_period;
  logic [DUR_W-1:0]    act_dur;
  logic [PRE_W-1:0]    presc;
  logic [PERIOD_W-1:0] phase;
  logic [10:0]         ms_cnt;
  logic [DUR_W-1:0]    elapsed;

  logic tick, ms_wrap, play_end, gap_end, slot_free, load, go_idle, accept;

  always_comb begin
    tick      = (state != IDLE) && (presc == PRE_MAX);
    ms_wrap   = tick && (ms_cnt == MS_MAX);
    play_end  = (state == PLAY) &&
                ((act_dur == '0) || (ms_wrap && (elapsed == act_dur - 1'b1)));
    gap_end   = (state == GAP) && ms_wrap && (elapsed == GAP_LEN - 1'b1);
    // The active slot frees at IDLE, at a gapless note end, or when the gap expires.
    slot_free = (state == IDLE) || (play_end && (GAP_MS == 0)) || gap_end;
    load      = slot_free && hold_valid;
    go_idle   = slot_free && !hold_valid && (state != IDLE);
    accept    = note_valid && note_ready;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      hold_valid  <= 1'b0;
      hold_period <= '0;
      hold_dur    <= '0;
      act_period  <= '0;
      act_dur     <= '0;
      presc       <= '0;
      phase       <= '0;
      ms_cnt      <= '0;
      elapsed     <= '0;
      note_ready  <= 1'b1;
      tone_out    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // Accept and drain are exclusive: accept needs an empty buffer, drain a full one.
      if (accept) begin
        hold_valid  <= 1'b1;
        hold_period <= note_period;
        hold_dur    <= note_dur;
        note_ready  <= 1'b0;
      end else if (load) begin
        hold_valid <= 1'b0;
        note_ready <= 1'b1;
      end

      done <= go_idle;
      if (go_idle || (state == IDLE && !hold_valid))
        busy <= accept;
      else
        busy <= 1'b1;

      if (load) begin
        state      <= PLAY;
        act_period <= hold_period;
        act_dur    <= hold_dur;
        presc      <= '0;
        phase      <= '0;
        ms_cnt     <= '0;
        elapsed    <= '0;
        tone_out   <= 1'b0;
      end else if (go_idle) begin
        state    <= IDLE;
        presc    <= '0;
        phase    <= '0;
        ms_cnt   <= '0;
        elapsed  <= '0;
        tone_out <= 1'b0;
      end else if (play_end) begin
        state    <= GAP;
        presc    <= '0;
        phase    <= '0;
        ms_cnt   <= '0;
        elapsed  <= '0;
        tone_out <= 1'b0;
      end else if (state != IDLE) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          ms_cnt <= ms_wrap ? '0 : ms_cnt + 1'b1;
          if (ms_wrap)
            elapsed <= elapsed + 1'b1;
          // Rests never advance the phase, so tone_out stays low.
          if (state == PLAY && act_period != '0) begin
            if (phase == act_period - 1'b1) begin
              phase    <= '0;
              tone_out <= ~tone_out;
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
